// File: rtl/register_wport_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
// Optional feature macro: REG_BYPASS_EN (staged-write bypass compare).
package register_wport_arbiter_pkg;

    localparam int NREQ_WB = 3;
    localparam int XLEN    = 32;
    localparam int RAW     = 5;
    localparam int NREG    = 32;

    // Regfile write bundle; field names match the regfile input struct.
    typedef struct packed {
        logic            wr_en;
        logic [RAW-1:0]  wr_addr;
        logic [XLEN-1:0] wr_data;
    } reg_wr_type;

    typedef struct packed {
        logic [NREQ_WB-1:0]      req_valid;
        logic [NREQ_WB*RAW-1:0]  req_waddr;
        logic [NREQ_WB*XLEN-1:0] req_wdata;
        logic                    sb_set;
        logic [RAW-1:0]          sb_addr;
    } reg_arb_in_type;

    typedef struct packed {
        logic [NREQ_WB-1:0] req_ready;
        logic               wr_en;
        logic [RAW-1:0]     wr_addr;
        logic [XLEN-1:0]    wr_data;
        logic [NREG-1:0]    busy;
    } reg_arb_out_type;

    // Pending-write scoreboard update: clear on commit, then set on issue.
    // A same-edge set wins because it belongs to a newer producer.
    function automatic logic [NREG-1:0] sb_next(
        input logic [NREG-1:0] cur,
        input logic            set,
        input logic [RAW-1:0]  saddr,
        input logic            clr,
        input logic [RAW-1:0]  caddr
    );
        logic [NREG-1:0] n;
        n = cur;
        if (clr) n[caddr] = 1'b0;
        if (set && (saddr != '0)) n[saddr] = 1'b1;
        n[0] = 1'b0;
        return n;
    endfunction

endpackage

// File: rtl/register_wport_arbiter_rr_arbiter.sv
// Generic N-wide round-robin picker with its rotating priority pointer.
// Search starts at the pointer and wraps; the pointer moves past each winner.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    // Pick the first requester at or after ptr, wrapping modulo N.
    always_comb begin
        int k;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr_q) + i;
            if (k >= N) k = k - N;
            if (!any_o && req_i[k]) begin
                any_o    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = IW'(k);
            end
        end
    end

    // Advance pointer to one past the winner; hold when idle.
    always_comb begin
        ptr_d = ptr_q;
        if (any_o) begin
            if (int'(idx_o) == N - 1) ptr_d = '0;
            else                      ptr_d = idx_o + IW'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end

endmodule

// File: rtl/register_wport_arbiter.sv
// Shares the regfile write port among NREQ writeback sources and
// tracks pending writes. Optional macro: REG_BYPASS_EN.
module register_wport_arbiter
    import register_wport_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_WB
) (
    input  logic               rst,
    input  logic               clk,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*5-1:0]  req_waddr,
    input  logic [NREQ*32-1:0] req_wdata,
    output logic               wr_en,
    output logic [4:0]         wr_addr,
    output logic [31:0]        wr_data,
    input  logic               sb_set,
    input  logic [4:0]         sb_addr,
`ifdef REG_BYPASS_EN
    input  logic [4:0]         byp_raddr1,
    input  logic [4:0]         byp_raddr2,
    output logic               byp_hit1,
    output logic               byp_hit2,
    output logic [31:0]        byp_data1,
    output logic [31:0]        byp_data2,
`endif
    output logic [31:0]        busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_any;
    logic [RAW-1:0]  sel_addr;
    logic [XLEN-1:0] sel_data;
    reg_wr_type      wr_q;
    reg_wr_type      wr_d;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr (
        .clk   (clk),
        .rst   (rst),
        .req_i (req_valid),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    assign req_ready = gnt;

    // Route the winning source's address and data.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_any && (gnt_idx == IW'(k))) begin
                sel_addr = req_waddr[5*k +: 5];
                sel_data = req_wdata[32*k +: 32];
            end
        end
    end

    // Stage the winner; x0 writes are consumed but never enabled.
    always_comb begin
        wr_d       = wr_q;
        wr_d.wr_en = 1'b0;
        if (gnt_any) begin
            wr_d.wr_en   = (sel_addr != '0);
            wr_d.wr_addr = sel_addr;
            wr_d.wr_data = sel_data;
        end
    end

    // Output staging register feeding the regfile write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wr_q <= '0;
        else      wr_q <= wr_d;
    end

    // Scoreboard next state: commit clears, issue sets, set wins.
    always_comb begin
        busy_d = sb_next(busy_q, sb_set, sb_addr,
                         wr_q.wr_en, wr_q.wr_addr);
    end

    // Pending-write scoreboard register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end

    assign wr_en   = wr_q.wr_en;
    assign wr_addr = wr_q.wr_addr;
    assign wr_data = wr_q.wr_data;
    assign busy    = busy_q;

`ifdef REG_BYPASS_EN
    // Forward the staged write to decode a cycle before it commits.
    always_comb begin
        byp_hit1  = wr_q.wr_en && (wr_q.wr_addr == byp_raddr1)
                    && (byp_raddr1 != '0);
        byp_hit2  = wr_q.wr_en && (wr_q.wr_addr == byp_raddr2)
                    && (byp_raddr2 != '0);
        byp_data1 = wr_q.wr_data;
        byp_data2 = wr_q.wr_data;
    end
`endif

endmodule
